// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one round per cycle over 16 cycles, with valid/ready on both sides.
// Optional DES_ZEROIZE_EN clears key/state/result registers on the output handshake.

module des_round (
  input  logic [31:0] xl,
  input  logic [31:0] xr,
  input  logic [47:0] k,
  output logic [31:0] rl,
  output logic [31:0] rr
);
  localparam logic [0:47][7:0] E_T = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                       16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam logic [0:31][7:0] P_T = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  // each S-box is 4 rows x 16 nibbles, row 0 column 0 in the top nibble
  localparam logic [0:7][255:0] S_T = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] ex, kx;
  logic [31:0] so, fo;
  logic [5:0]  b, idx;

  always_comb begin
    ex = '0; so = '0; fo = '0; b = '0; idx = '0;
    for (int i = 0; i < 48; i++) ex[6'(47-i)] = xr[5'(32-E_T[6'(i)])];
    kx = ex ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = kx[6'(42-6*j) +: 6];
      idx = {b[5], b[0], b[4:1]};
      so[5'(28-4*j) +: 4] = S_T[3'(j)][{~idx, 2'b00} +: 4];
    end
    for (int i = 0; i < 32; i++) fo[5'(31-i)] = so[5'(32-P_T[5'(i)])];
  end

  assign rl = xr;
  assign rr = xl ^ fo;
endmodule

module des_iter_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        dec,
  input  logic [63:0] key,
  input  logic [63:0] m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] r
);
  localparam logic [0:63][7:0] IP_T = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                        62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                        57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                        61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam logic [0:55][7:0] PC1_T = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                         60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                                         61,53,45,37,29,21,13,5,28,20,12,4};
  localparam logic [0:47][7:0] PC2_T = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                         41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63-i)] = x[6'(64-IP_T[6'(i)])];
    return y;
  endfunction

  // FP is the inverse of IP, so scatter through the IP table
  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(64-IP_T[6'(i)])] = x[6'(63-i)];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55-i)] = x[6'(64-PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47-i)] = x[6'(56-PC2_T[6'(i)])];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      st, nst;
  logic [31:0] lh, rh, rl, rr;
  logic [27:0] c, d, cn, dn;
  logic [3:0]  cnt;
  logic        dec_q, one_sh;
  logic [47:0] sk;
  logic [63:0] res;

  // shift-by-one rounds are 1, 2, 9, 16 for both directions
  assign one_sh = (cnt == 4'd0) || (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15);

  always_comb begin
    cn = c; dn = d;
    if (!dec_q) begin
      cn = one_sh ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
      dn = one_sh ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
    end else if (cnt != 4'd0) begin
      cn = one_sh ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
      dn = one_sh ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
    end
  end

  assign sk = pc2_f({cn, dn});

  des_round u_round (.xl(lh), .xr(rh), .k(sk), .rl(rl), .rr(rr));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= nst;

  always_comb begin
    nst = st; in_ready = 1'b0; out_valid = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nst = RUN;
      end
      RUN:  if (cnt == 4'd15) nst = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nst = IDLE;
      end
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lh <= '0; rh <= '0; c <= '0; d <= '0; cnt <= '0; dec_q <= 1'b0; res <= '0;
    end else if (in_valid && in_ready) begin
      {lh, rh} <= ip_f(m);
      {c, d}   <= pc1_f(key);
      dec_q    <= dec;
      cnt      <= '0;
    end else if (st == RUN) begin
      lh  <= rl;
      rh  <= rr;
      c   <= cn;
      d   <= dn;
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) res <= fp_f({rr, rl});
    end
`ifdef DES_ZEROIZE_EN
    else if (out_valid && out_ready) begin
      lh <= '0; rh <= '0; c <= '0; d <= '0; res <= '0;
    end
`else
`endif
  end

  assign r = res;
endmodule

// File: doc/des_iter_ctrl.md
# des_iter_ctrl

Iterative DES engine controller that sequences a single instance of the team's DES `round` datapath over 16 clock cycles to encrypt or decrypt one 64-bit block. It owns the initial and final permutations, the key schedule (PC-1, per-round rotation, PC-2) and the L/R state registers. It also owns a valid/ready handshake on both input and output. It sits between the host-side block interface and the combinational round function, and is the top-level DES primitive for the coursework SoC.

## Interface
- No parameters; round count fixed at 16.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request; `key`, `m` and `dec` are valid.
- `in_ready`  out  1  engine idle and able to accept; reset 1.
- `dec`  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- `key`  in  64  DES key with parity bits; bit 63 is DES bit 1; parity bits ignored.
- `m`  in  64  input block; bit 63 is DES bit 1.
- `out_valid`  out  1  `r` holds a result; reset 0.
- `out_ready`  in  1  consumer accepts the result.
- `r`  out  64  result block, FP(R16‖L16); reset 0.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready`: load L‖R ← IP(`m`), C‖D ← PC-1(`key`), latch `dec`, round counter ← 0, go to RUN.
- RUN: `in_ready`=0. Each cycle computes one round:
  - Drive the round with xl=L, xr=R, k=PC-2 of the current round's C‖D.
  - Register L←rl, R←rr and counter+1.
  - When counter is 15, the registered result is round 16; go to DONE.
- Key schedule, encrypt:
  - Round i subkey uses C,D rotated left by s_i, with s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Rotated values are stored.
- Key schedule, decrypt:
  - Round 1 uses C0,D0 unrotated.
  - Before round i>1, rotate right by t_i, with t = -,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotations operate independently on 28-bit C and D.
- DONE: `out_valid`=1 and `r`=FP(R‖L), i.e. halves swapped.
  - `r` is stable while `out_valid & ~out_ready`.
  - On `out_valid & out_ready`: go to IDLE and drop `out_valid` on the next edge.
  - No bypass: a new request cannot be accepted in the same cycle as the output handshake.
- `in_valid` asserted outside IDLE is ignored; there is no queuing.
- Inputs may change freely after accept; all operands are latched.

## Timing
- Accept edge = edge 0. Rounds complete on edges 1..16.
- `out_valid` rises after edge 16: latency 16 cycles from accept to result.
- Minimum issue interval is 18 cycles: accept, 16 RUN cycles, 1 DONE cycle with immediate `out_ready`. `in_ready` returns 1 the cycle after the output handshake.
- Critical path: C/D register → rotate mux → PC-2 → round (E, XOR, S-box, P, XOR) → L/R register.
- Async reset at any point:
  - Immediately `out_valid`=0, `in_ready`=1, `r`=0, state IDLE, counter 0.
  - An in-flight operation is discarded; no partial result is ever presented.
- Reset deassertion must be synchronised externally to `clk`.

## Configuration
- `DES_ZEROIZE_EN` defined:
  - On the output handshake edge, L, R, C, D and the result register clear to 0.
  - `r` reads 0 whenever `out_valid`=0.
- `DES_ZEROIZE_EN` undefined:
  - Internal registers retain their last values.
  - `r` continues to show the last result after the handshake until the next operation completes.
- Handshake timing and latency are identical either way.

## Test plan
- Encrypt: `key`=133457799BBCDFF1, `m`=0123456789ABCDEF, `dec`=0, `out_ready`=1 → `out_valid` exactly 16 cycles after accept, `r`=85E813540F0AB405.
- Decrypt: `key`=133457799BBCDFF1, `m`=85E813540F0AB405, `dec`=1 → `r`=0123456789ABCDEF. Also `key`=0E329232EA6D0D73, `m`=8787878787878787, encrypt → `r`=0000000000000000.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid` → `r` and `out_valid` stable and `in_ready`=0 throughout.
  - `in_valid` pulsed during RUN and DONE is ignored; the result is unchanged.
- Back-to-back:
  - Two requests with `in_valid` held high → second accepted exactly 1 cycle after the first output handshake; both results correct.
  - Flipping the `key` parity bits gives an identical result.
- Reset mid-operation:
  - Assert `rst_n`=0 at round 7 → `out_valid`=0 and `in_ready`=1 asynchronously.
  - After release, a fresh encrypt from the first vector returns 85E813540F0AB405.
- Zeroize:
  - With `DES_ZEROIZE_EN`, `r`=0 the cycle after the output handshake.
  - Without it, `r` still reads 85E813540F0AB405.
